// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, a single-entry decode slot,
// and redirect handling that drains any in-flight response before restarting.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;

    logic        slot_free;
    logic        req_fire;
    logic [31:0] redirect_target;

    // The slot counts as free when its current occupant leaves this same cycle,
    // which is what lets a response never find it occupied.
    assign slot_free       = !if_valid_q || if_ready;
    assign imem_req_valid  = !rst && (state_q == S_REQ) && slot_free;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_valid_q ? if_instr_q : NOP_INSTR;
    assign if_opcode = if_instr[6:0];

    // NOTE: all state uses non-blocking assignments; where two assignments to the
    // same register fire in one edge, the later one in program order wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_instr_q <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc_q       <= redirect_target;
            if_valid_q <= 1'b0;
            unique case (state_q)
                S_REQ:   state_q <= req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state_q <= imem_rsp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_q <= imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_q <= S_REQ;
            endcase
        end else begin
            if (if_valid_q && if_ready) begin
                if_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_q <= pc_q;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr_q <= imem_rsp_data;
                        if_pc_q    <= req_pc_q;
                        if_valid_q <= 1'b1;
                        pc_q       <= req_pc_q + 32'd4;
                        state_q    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule
